// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file:
// the sweep state encoding and the address legality rule.
package regfile_pkg;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  // Used by both the write path and every read port so they agree on legality.
  function automatic logic addr_legal(input int unsigned addr,
                                      input int unsigned nregs,
                                      input logic        zero_reg);
    return (addr < nregs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux plus ready, legality and bypass masking.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            ready_i,
  input  logic [AW-1:0]   readAddr_i,
  input  logic [XLEN-1:0] regs_i [NREGS],
  input  logic            wrValid_i,
  input  logic [AW-1:0]   wrAddr_i,
  input  logic [XLEN-1:0] wrData_i,
  output logic [XLEN-1:0] readData_o
);

  // Masking takes priority over bypass, and bypass over the stored value.
  always_comb begin
    readData_o = '0;
    if (ready_i && addr_legal(32'(readAddr_i), NREGS, ZERO_REG)) begin
      if (BYPASS && wrValid_i && (wrAddr_i == readAddr_i)) begin
        readData_o = wrData_i;
      end else begin
        readData_o = regs_i[readAddr_i];
      end
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-read register file with a post-reset clear sweep,
// optional hardwired zero register and optional write-to-read bypass.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int  XLEN     = 64,
  parameter int  NREGS    = 32,
  parameter int  NREAD    = 2,
  parameter bit  ZERO_REG = 1'b1,
  parameter bit  BYPASS   = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   ReadAddr,
  output logic [NREAD*XLEN-1:0] ReadData,
  input  logic [AW-1:0]         WriteReg,
  input  logic [XLEN-1:0]       WriteData,
  input  logic                  RegWrite,
  output logic                  ready
);

  logic            state_q, state_d;
  logic [AW-1:0]   clrIdx_q, clrIdx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic            writeLegal;
  logic            writeEn;

  assign writeLegal = RegWrite && addr_legal(32'(WriteReg), NREGS, ZERO_REG);
  assign writeEn    = ready_q && (state_q == ST_RUN) && writeLegal;
  assign ready      = ready_q;

  // The index stops at NREGS-1 instead of wrapping, so it is safe for any NREGS.
  always_comb begin
    state_d  = state_q;
    clrIdx_d = clrIdx_q;
    ready_d  = ready_q;
    if (state_q == ST_CLEAR) begin
      if (clrIdx_q == AW'(NREGS - 1)) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        clrIdx_d = clrIdx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      clrIdx_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
      ready_q  <= ready_d;
    end
  end

  // Reset itself leaves the array alone; the sweep that follows does the clearing.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        rf_q[clrIdx_q] <= '0;
      end else if (writeEn) begin
        rf_q[WriteReg] <= WriteData;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : gen_read
    regfile_read_port #(
      .XLEN    (XLEN),
      .NREGS   (NREGS),
      .AW      (AW),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) uReadPort (
      .ready_i   (ready_q),
      .readAddr_i(ReadAddr[k*AW +: AW]),
      .regs_i    (rf_q),
      .wrValid_i (writeLegal),
      .wrAddr_i  (WriteReg),
      .wrData_i  (WriteData),
      .readData_o(ReadData[k*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: a default-configured instance (A) and a 24-entry,
// 3-port, no-zero-register, no-bypass instance (B) against a behavioural model.
module tb_regfile_multiport;

  localparam int X  = 64;
  localparam int NA = 32;
  localparam int RA = 2;
  localparam int NB = 24;
  localparam int RB = 3;
  localparam int AWX = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic [RA*AWX-1:0] raA;
  logic [RA*X-1:0]   rdA;
  logic [AWX-1:0]    wrA;
  logic [X-1:0]      wdA;
  logic              weA;
  logic              readyA;

  logic [RB*AWX-1:0] raB;
  logic [RB*X-1:0]   rdB;
  logic [AWX-1:0]    wrB;
  logic [X-1:0]      wdB;
  logic              weB;
  logic              readyB;

  regfile_multiport dutA (
    .clock(clock), .reset(reset), .ReadAddr(raA), .ReadData(rdA),
    .WriteReg(wrA), .WriteData(wdA), .RegWrite(weA), .ready(readyA)
  );

  regfile_multiport #(
    .XLEN(64), .NREGS(NB), .NREAD(RB), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dutB (
    .clock(clock), .reset(reset), .ReadAddr(raB), .ReadData(rdB),
    .WriteReg(wrB), .WriteData(wdB), .RegWrite(weB), .ready(readyB)
  );

  // Behavioural model: contents, ready flag and cycles since reset released
  logic [X-1:0] mA [NA];
  logic [X-1:0] mB [NB];
  bit mReadyA, mReadyB;
  int cntA, cntB;
  int total = 0;
  int bad   = 0;

  function automatic logic [X-1:0] expA(input int addr);
    if (!mReadyA || addr >= NA || addr == 0) return '0;
    if (weA && int'(wrA) != 0 && int'(wrA) == addr) return wdA;
    return mA[addr];
  endfunction

  function automatic logic [X-1:0] expB(input int addr);
    if (!mReadyB || addr >= NB) return '0;
    return mB[addr];
  endfunction

  // Advance the model by one clock using the inputs currently applied, then clock the DUTs
  task automatic tick();
    if (reset) begin
      cntA = 0; cntB = 0; mReadyA = 0; mReadyB = 0;
      for (int i = 0; i < NA; i++) mA[i] = '0;
      for (int i = 0; i < NB; i++) mB[i] = '0;
    end else begin
      if (!mReadyA) begin
        cntA++;
        if (cntA == NA) mReadyA = 1;
      end else if (weA && int'(wrA) != 0) begin
        mA[wrA] = wdA;
      end
      if (!mReadyB) begin
        cntB++;
        if (cntB == NB) mReadyB = 1;
      end else if (weB && int'(wrB) < NB) begin
        mB[wrB] = wdB;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    raA = '0; wrA = '0; wdA = '0; weA = 1'b0;
    raB = '0; wrB = '0; wdB = '0; weB = 1'b0;
  endtask

  task automatic test_reset();
    int riseA, riseB;
    reset = 1'b1;
    idleInputs();
    repeat (3) tick();
    total++;
    if (readyA !== 1'b0 || readyB !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ready got=%b%b exp=00", readyA, readyB);
    end
    reset = 1'b0;
    weA = 1'b1; wrA = 5'd5; wdA = 64'hDEAD;
    weB = 1'b1; wrB = 5'd5; wdB = 64'hDEAD;
    riseA = 0; riseB = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 20) begin weA = 1'b0; weB = 1'b0; end
      total++;
      if (readyA !== mReadyA || readyB !== mReadyB) begin
        bad++; $display("[TB] FAIL sweep_ready cyc=%0d got=%b%b exp=%b%b", c, readyA, readyB, mReadyA, mReadyB);
      end
      if (readyA === 1'b1 && riseA == 0) riseA = c;
      if (readyB === 1'b1 && riseB == 0) riseB = c;
    end
    total++;
    if (riseA != 32 || riseB != 24) begin
      bad++; $display("[TB] FAIL sweep_len got=%0d/%0d exp=32/24", riseA, riseB);
    end
    weA = 1'b0; weB = 1'b0;
    for (int i = 0; i < NA; i++) begin
      raA = {5'(NA - 1 - i), 5'(i)};
      raB = {5'(i % NB), 5'(i % NB), 5'(i % NB)};
      #1;
      total++;
      if (rdA !== '0 || rdB !== '0) begin
        bad++; $display("[TB] FAIL cleared reg=%0d gotA=%h gotB=%h exp=0", i, rdA, rdB);
      end
    end
  endtask

  task automatic test_basic_rw();
    weA = 1'b1; wrA = 5'd7;  wdA = 64'h0123_4567_89AB_CDEF; tick();
    wrA = 5'd31; wdA = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    weA = 1'b0;
    weB = 1'b1; wrB = 5'd7;  wdB = 64'h0123_4567_89AB_CDEF; tick();
    wrB = 5'd23; wdB = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    weB = 1'b0;
    raA = {5'd31, 5'd7};
    raB = {5'd23, 5'd23, 5'd7};
    #1;
    total++;
    if (rdA[0 +: X] !== 64'h0123_4567_89AB_CDEF || rdA[X +: X] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++; $display("[TB] FAIL basic_A got=%h exp=ffffffffffffffff0123456789abcdef", rdA);
    end
    total++;
    if (rdB[0 +: X] !== 64'h0123_4567_89AB_CDEF || rdB[X +: X] !== 64'hFFFF_FFFF_FFFF_FFFF
        || rdB[2*X +: X] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++; $display("[TB] FAIL basic_B got=%h", rdB);
    end
  endtask

  task automatic test_zero_reg();
    weA = 1'b1; wrA = 5'd0; wdA = 64'h55;
    weB = 1'b1; wrB = 5'd0; wdB = 64'h55;
    tick();
    weA = 1'b0; weB = 1'b0;
    raA = {5'd0, 5'd0};
    raB = {5'd0, 5'd0, 5'd0};
    #1;
    total++;
    if (rdA !== '0) begin
      bad++; $display("[TB] FAIL zero_reg_A got=%h exp=0", rdA);
    end
    total++;
    if (rdB[0 +: X] !== 64'h55) begin
      bad++; $display("[TB] FAIL zero_reg_B got=%h exp=55", rdB[0 +: X]);
    end
  endtask

  task automatic test_bypass();
    weA = 1'b1; wrA = 5'd9; wdA = 64'h111;
    weB = 1'b1; wrB = 5'd9; wdB = 64'h111;
    tick();
    wdA = 64'hABC; wdB = 64'hABC;
    raA = {5'd0, 5'd9};
    raB = {5'd0, 5'd0, 5'd9};
    #1;
    total++;
    if (rdA[0 +: X] !== 64'hABC) begin
      bad++; $display("[TB] FAIL bypass_A got=%h exp=abc", rdA[0 +: X]);
    end
    total++;
    if (rdB[0 +: X] !== 64'h111) begin
      bad++; $display("[TB] FAIL nobypass_old got=%h exp=111", rdB[0 +: X]);
    end
    tick();
    weA = 1'b0; weB = 1'b0;
    #1;
    total++;
    if (rdA[0 +: X] !== 64'hABC || rdB[0 +: X] !== 64'hABC) begin
      bad++; $display("[TB] FAIL bypass_after gotA=%h gotB=%h exp=abc", rdA[0 +: X], rdB[0 +: X]);
    end
  endtask

  task automatic test_nonpow2();
    weB = 1'b1; wrB = 5'd27; wdB = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    weB = 1'b0;
    for (int i = 0; i < NB; i += 3) begin
      raB = {5'(i + 2), 5'(i + 1), 5'(i)};
      #1;
      for (int k = 0; k < RB; k++) begin
        total++;
        if (rdB[k*X +: X] !== expB(i + k)) begin
          bad++; $display("[TB] FAIL np2_contents reg=%0d got=%h exp=%h", i + k, rdB[k*X +: X], expB(i + k));
        end
      end
    end
    raB = {5'd27, 5'd27, 5'd27};
    #1;
    total++;
    if (rdB !== '0) begin
      bad++; $display("[TB] FAIL np2_oob_read got=%h exp=0", rdB);
    end
    weB = 1'b1; wrB = 5'd3; wdB = 64'h3333; tick();
    wrB = 5'd23; wdB = 64'h2323; tick();
    weB = 1'b0;
    raB = {5'd23, 5'd3, 5'd3};
    #1;
    total++;
    if (rdB[0 +: X] !== 64'h3333 || rdB[X +: X] !== 64'h3333 || rdB[2*X +: X] !== 64'h2323) begin
      bad++; $display("[TB] FAIL np2_multiport got=%h", rdB);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      weA = 1'($urandom); wrA = 5'($urandom); wdA = {$urandom, $urandom};
      weB = 1'($urandom); wrB = 5'($urandom_range(0, 31)); wdB = {$urandom, $urandom};
      raA = RA*AWX'({$urandom});
      raB = RB*AWX'({$urandom});
      #1;
      for (int k = 0; k < RA; k++) begin
        total++;
        if (rdA[k*X +: X] !== expA(int'(raA[k*AWX +: AWX]))) begin
          bad++; $display("[TB] FAIL rand_A cyc=%0d port=%0d got=%h exp=%h", c, k, rdA[k*X +: X], expA(int'(raA[k*AWX +: AWX])));
        end
      end
      for (int k = 0; k < RB; k++) begin
        total++;
        if (rdB[k*X +: X] !== expB(int'(raB[k*AWX +: AWX]))) begin
          bad++; $display("[TB] FAIL rand_B cyc=%0d port=%0d got=%h exp=%h", c, k, rdB[k*X +: X], expB(int'(raB[k*AWX +: AWX])));
        end
      end
      tick();
    end
    weA = 1'b0; weB = 1'b0;
  endtask

  task automatic test_mid_reset();
    int riseA, riseB;
    for (int r = 1; r <= 4; r++) begin
      weA = 1'b1; wrA = 5'(r); wdA = 64'(r * 'h11);
      weB = 1'b1; wrB = 5'(r); wdB = 64'(r * 'h11);
      tick();
    end
    weA = 1'b0; weB = 1'b0;
    raA = {5'd4, 5'd1};
    #1;
    total++;
    if (rdA[0 +: X] !== 64'h11 || rdA[X +: X] !== 64'h44) begin
      bad++; $display("[TB] FAIL pre_reset_data got=%h", rdA);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    riseA = 0; riseB = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (readyA === 1'b1 && riseA == 0) riseA = c;
      if (readyB === 1'b1 && riseB == 0) riseB = c;
    end
    total++;
    if (riseA != 32 || riseB != 24) begin
      bad++; $display("[TB] FAIL restart_len got=%0d/%0d exp=32/24", riseA, riseB);
    end
    for (int r = 1; r <= 4; r += 2) begin
      raA = {5'(r + 1), 5'(r)};
      raB = {5'(r + 1), 5'(r + 1), 5'(r)};
      #1;
      total++;
      if (rdA !== '0 || rdB !== '0) begin
        bad++; $display("[TB] FAIL recleared reg=%0d gotA=%h gotB=%h exp=0", r, rdA, rdB);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    test_reset();
    test_basic_rw();
    test_zero_reg();
    test_bypass();
    test_nonpow2();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised successor to the core's 2-read/1-write integer register file. Generalised in data width, register count and read-port count. Adds three features:
- Optional hardwired-zero register 0.
- Optional write-to-read bypass.
- A synchronous reset sweep that clears every entry, one per cycle, while holding `ready` low.

It sits in the decode stage. It feeds the ALU operand muxes and takes writeback from the last pipeline stage.

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of registers (2..256, need not be a power of 2)
NREAD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports
(derived) AW = $clog2(NREGS), address width

Ports:
clock  in  1  rising-edge clock for all state
reset  in  1  synchronous, active-high reset
ReadAddr  in  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW]
ReadData  out  NREAD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN]
WriteReg  in  AW  write address
WriteData  in  XLEN  write data
RegWrite  in  1  write enable
ready  out  1  high once the clear sweep has finished; writes are accepted only when high

Behaviour:
- State machine has two states: CLEAR and RUN. A bit-vector encoding is acceptable.
- Reset:
  - While `reset` is sampled high at a posedge: state <= CLEAR, clr_idx <= 0, ready <= 0. No array entry is written.
- CLEAR state (reset low):
  - Each posedge writes 0 to RF[clr_idx] and increments clr_idx.
  - When clr_idx == NREGS-1 is written, state <= RUN and ready <= 1.
  - `ready` therefore rises exactly NREGS posedges after the first posedge with reset low.
- RUN state:
  - On a posedge with RegWrite=1 and a legal WriteReg, RF[WriteReg] <= WriteData.
  - WriteReg is illegal if it is >= NREGS, or if ZERO_REG=1 and WriteReg == 0. Illegal writes are silently dropped.
- Writes while ready=0 are ignored. RegWrite has no effect during CLEAR.
- Reset asserted mid-sweep restarts the sweep at index 0. Reset asserted in RUN re-enters CLEAR, and all contents are cleared again.
- Reads are combinational, with zero latency. For each port k, ReadData[k] is chosen by the first matching rule:
  1. ready == 0 gives 0.
  2. ReadAddr[k] >= NREGS gives 0.
  3. ZERO_REG=1 and ReadAddr[k] == 0 gives 0.
  4. BYPASS=1, RegWrite=1, the write is legal and WriteReg == ReadAddr[k] gives WriteData (same cycle).
  5. Otherwise, RF[ReadAddr[k]].
- With BYPASS=0, a read of the register being written returns the old value until the posedge, and the new value after it.
- Multiple ports reading the same address all return the identical value.
- No arithmetic is performed. Widths are exact. clr_idx is AW bits wide and is compared against NREGS-1, so it never wraps.
- Array contents before the first reset are undefined. Behaviour is defined only after one reset.

Decomposition:
- Shared package regfile_pkg holds:
  - State encoding constants ST_CLEAR and ST_RUN.
  - An addr_legal(addr, nregs, zero_reg) function, used by both the write path and the read path.
- One sub-module, regfile_read_port. It contains one read mux plus the zero/bypass/ready masking. It is instantiated NREAD times in a generate loop.
- The array, the clear sweep FSM and the write logic stay in the top module.

Test Plan:
- Reset sweep: hold reset for 3 cycles, then release (defaults) -> ready is 0 for exactly 32 cycles and rises on the 32nd posedge; all 32 registers then read 0x0. RegWrite=1 to reg 5 with 0xDEAD during the sweep -> reg 5 still reads 0.
- Basic write/read: write reg 7 = 0x0123_4567_89AB_CDEF, reg 31 = 0xFFFF_FFFF_FFFF_FFFF; then ReadAddr = {31, 7} -> ReadData port0 = 0x0123..CDEF, port1 = 0xFFFF..FFFF.
- Zero register: write reg 0 = 0x55 -> reads 0. Rerun with ZERO_REG=0 -> reads 0x55.
- Bypass: RegWrite=1, WriteReg=9, WriteData=0xABC, ReadAddr0=9 in the same cycle -> with BYPASS=1, ReadData0 = 0xABC before the edge; with BYPASS=0 it shows the old value, then 0xABC after the edge.
- Non-power-of-2: NREGS=24, NREAD=3. Write to address 27 -> no entry changes; reading address 27 returns 0. Three ports reading {3, 3, 23} after writes return consistent values.
- Reset mid-operation: after regs 1..4 are written with 0x11..0x44, assert reset for 1 cycle at sweep index 10 of a second reset -> the sweep restarts, ready is low for 32 more cycles, and regs 1..4 read 0.
